mem_align_unit: RTL and testbench

- Parametrised load/store alignment engine between the MEM stage and the data-memory port.
- Generalises the fixed lb/lbu/lh/lhu/lw writeback selection to XLEN 32 or 64, with a dword size at XLEN=64.
- Adds misaligned-access support: one request is split into two aligned memory transactions, and load bytes are merged and sign/zero-extended.
- Single outstanding request, valid/ready on the core side, read/write + resp on the memory side.

---
 rtl/mem_align_pkg.sv | 23 ++
 rtl/load_extend.sv | 39 +++
 rtl/mem_align_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_align_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_pkg.sv
// rtl/mem_align_pkg.sv - shared types and helpers for the load/store alignment engine
package mem_align_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } align_state_t;

    // n contiguous byte enables starting at lane off; callers truncate to the beat width
    function automatic logic [7:0] byte_mask(input int off, input int n);
        return 8'(((32'd1 << n) - 32'd1) << off);
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - merges the two load beats at the request offset and sign/zero-extends
module load_extend
    import mem_align_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  beat0,
    input  logic [XLEN-1:0]  beat1,
    input  logic [OFF_W-1:0] off,
    input  mem_size_t        size,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] lowpart;
    int              nbits;
    int              shl;

    always_comb begin
        merged  = XLEN'({beat1, beat0} >> (8 * int'(off)));
        nbits   = 8 << size;
        shl     = 0;
        lowpart = merged;
        rdata   = merged;
        // left-justify the wanted bytes, then shift back to extend from the top bit
        if (nbits < XLEN) begin
            shl     = XLEN - nbits;
            lowpart = merged << shl;
            if (is_unsigned) begin
                rdata = lowpart >> shl;
            end else begin
                rdata = $signed(lowpart) >>> shl;
            end
        end
    end

endmodule

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - splits misaligned loads/stores into aligned beats and merges load data
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_wmask,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_resp
);

    localparam int B     = XLEN / 8;
    localparam int OFF_W = $clog2(B);

    align_state_t      state, state_nxt;
    logic              r_write, r_unsigned;
    mem_size_t         r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata, beat0, beat1;

    logic              accept, f_write, f_unsigned, f_err, split;
    mem_size_t         f_size;
    logic [ADDR_W-1:0] f_addr, base_addr;
    logic [XLEN-1:0]   f_wdata, beat0_nxt, beat1_nxt, ext_data;
    int                off_i, n_i;

    logic              req_ready_nxt, resp_valid_nxt, resp_err_nxt, mem_read_nxt, mem_write_nxt;
    logic [XLEN-1:0]   resp_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [B-1:0]      mem_wmask_nxt;

    // request fields as seen by the next cycle: live inputs on acceptance, latched copy otherwise
    always_comb begin
        accept     = (state == ST_IDLE) && req_valid;
        f_write    = accept ? req_write : r_write;
        f_unsigned = accept ? req_unsigned : r_unsigned;
        f_size     = accept ? mem_size_t'(req_size) : r_size;
        f_addr     = accept ? req_addr : r_addr;
        f_wdata    = accept ? req_wdata : r_wdata;
        off_i      = int'(f_addr[OFF_W-1:0]);
        n_i        = 1 << f_size;
        f_err      = (8 * n_i) > XLEN;
        split      = (off_i + n_i) > B;
        base_addr  = f_addr & ~ADDR_W'(B - 1);
        beat0_nxt  = (state == ST_ACC0 && mem_resp && !r_write) ? mem_rdata : beat0;
        beat1_nxt  = (state == ST_ACC1 && mem_resp && !r_write) ? mem_rdata : beat1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = f_err ? ST_RESP : ST_ACC0;
            ST_ACC0: if (mem_resp) state_nxt = split ? ST_ACC1 : ST_RESP;
            ST_ACC1: if (mem_resp) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_nxt  = (state_nxt == ST_IDLE);
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
        mem_read_nxt   = 1'b0;
        mem_write_nxt  = 1'b0;
        mem_addr_nxt   = '0;
        mem_wmask_nxt  = '0;
        mem_wdata_nxt  = '0;
        case (state_nxt)
            ST_ACC0: begin
                mem_read_nxt  = !f_write;
                mem_write_nxt = f_write;
                mem_addr_nxt  = base_addr;
                mem_wmask_nxt = B'(byte_mask(off_i, n_i));
                mem_wdata_nxt = f_wdata << (8 * off_i);
            end
            ST_ACC1: begin
                mem_read_nxt  = !f_write;
                mem_write_nxt = f_write;
                mem_addr_nxt  = base_addr + ADDR_W'(B);
                mem_wmask_nxt = B'(byte_mask(0, off_i + n_i - B));
                mem_wdata_nxt = f_wdata >> (8 * (B - off_i));
            end
            ST_RESP: begin
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = f_err;
                resp_rdata_nxt = (f_write || f_err) ? '0 : ext_data;
            end
            default: ;
        endcase
    end

    load_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extend (
        .beat0       (beat0_nxt),
        .beat1       (beat1_nxt),
        .off         (f_addr[OFF_W-1:0]),
        .size        (f_size),
        .is_unsigned (f_unsigned),
        .rdata       (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            beat0      <= '0;
            beat1      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
        end else begin
            if (accept) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= mem_size_t'(req_size);
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            beat0      <= beat0_nxt;
            beat1      <= beat1_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wmask  <= mem_wmask_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - self-checking bench for mem_align_unit at XLEN=32
module tb_mem_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_resp;

    always #5 clk = ~clk;

    mem_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          obs_n, obs_lat, obs_first;
    logic [31:0] obs_addr [4];
    logic [3:0]  obs_mask [4];
    logic [31:0] obs_wdata [4];
    logic        obs_isw [4];
    logic [31:0] obs_rdata;
    logic        obs_err, obs_timeout, obs_both, obs_after_valid, obs_after_ready;
    logic        use_fixed;
    logic [31:0] fixed_data [2];

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    // issue one request, act as the memory, record beats and the response
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input int lat);
        int cyc, wait_cnt, resp_cyc, j;
        logic pending, done;
        logic [31:0] ba;
        obs_n = 0; obs_timeout = 1'b0; obs_both = 1'b0; obs_first = -1;
        obs_rdata = '0; obs_err = 1'b0; obs_lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0; pending = 1'b0; done = 1'b0; resp_cyc = -1; wait_cnt = 0;
        while (!done && cyc < 200) begin
            if (mem_resp) begin
                mem_resp = 1'b0; mem_rdata = '0; pending = 1'b0;
            end
            if (mem_read && mem_write) obs_both = 1'b1;
            if (resp_valid) begin
                obs_rdata = resp_rdata; obs_err = resp_err; obs_lat = cyc - resp_cyc;
                done = 1'b1;
            end else begin
                if ((mem_read || mem_write) && !pending) begin
                    j = obs_n;
                    if (j < 4) begin
                        obs_addr[j] = mem_addr; obs_mask[j] = mem_wmask;
                        obs_wdata[j] = mem_wdata; obs_isw[j] = mem_write;
                    end
                    if (obs_first < 0) obs_first = cyc;
                    obs_n++;
                    pending = 1'b1; wait_cnt = 0;
                end
                if (pending) begin
                    if (wait_cnt == lat) begin
                        ba = mem_addr;
                        if (use_fixed && obs_n <= 2) mem_rdata = fixed_data[obs_n-1];
                        else mem_rdata = {model_byte(ba + 3), model_byte(ba + 2),
                                          model_byte(ba + 1), model_byte(ba)};
                        mem_resp = 1'b1; resp_cyc = cyc;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) obs_timeout = 1'b1;
        @(negedge clk);
        obs_after_valid = resp_valid; obs_after_ready = req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0)
            $display("FAIL reset_strobes: got %b expected 0000", {resp_valid, resp_err, mem_read, mem_write});
        else pass_cnt++;
        total_cnt++;
        if ({resp_rdata, mem_addr, mem_wmask, mem_wdata} !== 100'b0)
            $display("FAIL reset_data: got %h expected 0", {resp_rdata, mem_addr, mem_wmask, mem_wdata});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_lw();
        use_fixed = 1'b1; fixed_data[0] = 32'hDEADBEEF;
        run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        total_cnt++;
        if (obs_timeout || obs_n !== 1 || obs_addr[0] !== 32'h100 || obs_isw[0] !== 1'b0 || obs_first !== 0)
            $display("FAIL lw_beat: got n=%0d addr=%h w=%b first=%0d expected n=1 addr=00000100 w=0 first=0",
                     obs_n, obs_addr[0], obs_isw[0], obs_first);
        else pass_cnt++;
        total_cnt++;
        if (obs_rdata !== 32'hDEADBEEF || obs_lat !== 1)
            $display("FAIL lw_resp: got %h lat %0d expected deadbeef lat 1", obs_rdata, obs_lat);
        else pass_cnt++;
        total_cnt++;
        if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1)
            $display("FAIL lw_pulse: got valid %b ready %b expected 0 1", obs_after_valid, obs_after_ready);
        else pass_cnt++;
    endtask

    task automatic test_lb_lbu();
        use_fixed = 1'b1; fixed_data[0] = 32'h80112233;
        run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1);
        total_cnt++;
        if (obs_n !== 1 || obs_addr[0] !== 32'h100 || obs_rdata !== 32'hFFFFFF80)
            $display("FAIL lb: got n=%0d addr=%h data=%h expected 1 00000100 ffffff80", obs_n, obs_addr[0], obs_rdata);
        else pass_cnt++;
        run_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 2);
        total_cnt++;
        if (obs_n !== 1 || obs_addr[0] !== 32'h100 || obs_rdata !== 32'h00000080)
            $display("FAIL lbu: got n=%0d addr=%h data=%h expected 1 00000100 00000080", obs_n, obs_addr[0], obs_rdata);
        else pass_cnt++;
    endtask

    task automatic test_misaligned_lw();
        use_fixed = 1'b1; fixed_data[0] = 32'h44332211; fixed_data[1] = 32'h88776655;
        run_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
        total_cnt++;
        if (obs_n !== 2 || obs_addr[0] !== 32'h100 || obs_addr[1] !== 32'h104)
            $display("FAIL mis_lw_beats: got n=%0d %h %h expected 2 00000100 00000104", obs_n, obs_addr[0], obs_addr[1]);
        else pass_cnt++;
        total_cnt++;
        if (obs_rdata !== 32'h66554433 || obs_lat !== 1)
            $display("FAIL mis_lw_resp: got %h lat %0d expected 66554433 lat 1", obs_rdata, obs_lat);
        else pass_cnt++;
    endtask

    task automatic test_misaligned_sh();
        use_fixed = 1'b0;
        run_req(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000ABCD, 1);
        total_cnt++;
        if (obs_n !== 2 || obs_addr[0] !== 32'h1000 || obs_mask[0] !== 4'b1000 ||
            obs_wdata[0] !== 32'hCD000000 || obs_isw[0] !== 1'b1)
            $display("FAIL sh_beat0: got n=%0d %h %b %h w=%b expected 2 00001000 1000 cd000000 w=1",
                     obs_n, obs_addr[0], obs_mask[0], obs_wdata[0], obs_isw[0]);
        else pass_cnt++;
        total_cnt++;
        if (obs_addr[1] !== 32'h1004 || obs_mask[1] !== 4'b0001 || obs_wdata[1] !== 32'h000000AB || obs_isw[1] !== 1'b1)
            $display("FAIL sh_beat1: got %h %b %h w=%b expected 00001004 0001 000000ab w=1",
                     obs_addr[1], obs_mask[1], obs_wdata[1], obs_isw[1]);
        else pass_cnt++;
        total_cnt++;
        if (obs_rdata !== 32'h0 || obs_err !== 1'b0)
            $display("FAIL sh_resp: got %h err %b expected 00000000 err 0", obs_rdata, obs_err);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_illegal();
        logic [31:0] ev;
        use_fixed = 1'b0;
        run_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 0);
        ev = {model_byte(32'h1), model_byte(32'h0), model_byte(32'hFFFFFFFF), model_byte(32'hFFFFFFFE)};
        total_cnt++;
        if (obs_n !== 2 || obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h0 || obs_rdata !== ev)
            $display("FAIL wrap_lw: got n=%0d %h %h data %h expected 2 fffffffc 00000000 data %h",
                     obs_n, obs_addr[0], obs_addr[1], obs_rdata, ev);
        else pass_cnt++;
        run_req(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 0);
        total_cnt++;
        if (obs_n !== 0 || obs_err !== 1'b1 || obs_lat !== 1 || obs_rdata !== 32'h0)
            $display("FAIL illegal_size: got n=%0d err %b lat %0d data %h expected 0 1 1 00000000",
                     obs_n, obs_err, obs_lat, obs_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_acc1();
        logic saw_valid;
        use_fixed = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h102;
        @(negedge clk);
        req_valid = 1'b0;
        mem_resp = 1'b1; mem_rdata = 32'h44332211;
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        total_cnt++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h104)
            $display("FAIL rst_acc1_setup: got read %b addr %h expected 1 00000104", mem_read, mem_addr);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_read !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_async: got read %b ready %b expected 0 1", mem_read, req_ready);
        else pass_cnt++;
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL rst_no_resp: got resp_valid %b expected 0", saw_valid);
        else pass_cnt++;
        run_req(1'b0, 2'd1, 1'b1, 32'h302, 32'h0, 1);
        total_cnt++;
        if (obs_n !== 1 || obs_rdata !== {16'h0, model_byte(32'h303), model_byte(32'h302)})
            $display("FAIL rst_recover: got n=%0d data %h expected 1 %h", obs_n, obs_rdata,
                     {16'h0, model_byte(32'h303), model_byte(32'h302)});
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic        w, u, ee;
            logic [1:0]  sz;
            logic [31:0] a, wd, ev, ba;
            logic [31:0] ea [2];
            logic [3:0]  em [2];
            logic [31:0] ew [2];
            logic [31:0] wm [2];
            int          n, lat, en, lane;
            w   = 1'($urandom_range(0, 1));
            u   = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
            wd  = $urandom;
            lat = $urandom_range(0, 3);
            use_fixed = 1'b0;
            run_req(w, sz, u, a, wd, lat);
            n = 1 << sz; en = 0; ev = '0; ee = (sz == 2'd3);
            for (int j = 0; j < 2; j++) begin
                ea[j] = '0; em[j] = '0; ew[j] = '0; wm[j] = '0;
            end
            if (!ee) begin
                for (int k = 0; k < n; k++) begin
                    ba   = (a + k) & 32'hFFFFFFFC;
                    lane = int'((a + k) & 32'h3);
                    if (en == 0 || ba != ea[en-1]) en++;
                    ea[en-1] = ba;
                    em[en-1][lane] = 1'b1;
                    ew[en-1][8*lane +: 8] = wd[8*k +: 8];
                    wm[en-1][8*lane +: 8] = 8'hFF;
                    ev[8*k +: 8] = model_byte(a + k);
                end
                if (!u && n < 4 && ev[8*n-1])
                    for (int b = 8 * n; b < 32; b++) ev[b] = 1'b1;
                if (w) ev = '0;
            end
            total_cnt++;
            if (obs_timeout || obs_lat !== 1 || obs_both || obs_after_valid !== 1'b0)
                $display("FAIL rnd%0d_timing: got timeout %b lat %0d both %b after %b expected 0 1 0 0",
                         t, obs_timeout, obs_lat, obs_both, obs_after_valid);
            else pass_cnt++;
            total_cnt++;
            if (obs_n !== en) $display("FAIL rnd%0d_beats: got %0d expected %0d", t, obs_n, en);
            else pass_cnt++;
            for (int j = 0; j < en && j < obs_n; j++) begin
                total_cnt++;
                if (obs_addr[j] !== ea[j] || obs_mask[j] !== em[j] || obs_isw[j] !== w ||
                    (w && ((obs_wdata[j] & wm[j]) !== ew[j])))
                    $display("FAIL rnd%0d_beat%0d: got %h %b w=%b %h expected %h %b w=%b %h",
                             t, j, obs_addr[j], obs_mask[j], obs_isw[j], obs_wdata[j] & wm[j],
                             ea[j], em[j], w, ew[j]);
                else pass_cnt++;
            end
            total_cnt++;
            if (obs_rdata !== ev || obs_err !== ee)
                $display("FAIL rnd%0d_resp: got %h err %b expected %h err %b", t, obs_rdata, obs_err, ev, ee);
            else pass_cnt++;
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0; use_fixed = 1'b0;
        fixed_data[0] = '0; fixed_data[1] = '0;
        test_reset();
        test_aligned_lw();
        test_lb_lbu();
        test_misaligned_lw();
        test_misaligned_sh();
        test_wrap_and_illegal();
        test_reset_acc1();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
